floor_call_panel: RTL and testbench

- Request-issuing end of the lift request interface. Collects floor-call buttons and debounces them.
- Keeps a lamp (pending) bit per floor and presents one floor at a time on req_floor/req_valid to the lift controller.
- The lift controller latches a request whenever req_floor changes. This block guarantees that every unsent call produces a fresh, held value.
- A call clears when the car reports current_floor equal to that floor with door open.

---
 rtl/floor_call_panel.sv | 169 ++++++++++++++++
 tb/tb_floor_call_panel.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/floor_call_panel.sv
// Floor-call panel: synchronises and debounces call buttons, keeps one lamp per
// floor and issues pending calls to the lift controller one at a time.
module floor_call_panel #(
  parameter int unsigned FLOORS   = 8,
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned HOLD     = 3,
  parameter int unsigned GAP      = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLOORS-1:0] btn,
  input  logic [2:0]        current_floor,
  input  logic [1:0]        door,
  input  logic              emergency_stop,
  output logic [2:0]        req_floor,
  output logic              req_valid,
  output logic [FLOORS-1:0] lamps,
  output logic              busy
);

  localparam int unsigned PW   = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
  localparam int unsigned CMAX = (HOLD > GAP) ? HOLD : GAP;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP
  } state_t;

  logic [FLOORS-1:0] sync1_q, sync2_q;
  logic [PW-1:0]     presc_q, presc_d;
  logic              tick;
  logic [FLOORS-1:0] hist0_q, hist0_d, hist1_q, hist1_d;
  logic [FLOORS-1:0] deb_q, deb_d;
  logic [FLOORS-1:0] press;
  logic [FLOORS-1:0] lamps_q, lamps_d;
  logic [FLOORS-1:0] sent_q, sent_d;
  logic [FLOORS-1:0] clr_mask, issue_mask;
  logic [FLOORS-1:0] avail, others, pool;
  logic [2:0]        last_q, last_d;
  logic [2:0]        cand, idx;
  logic              found, fresh;
  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [2:0]        req_floor_q, req_floor_d;
  logic              req_valid_q, req_valid_d;
  logic              fresh_q, fresh_d;
  logic              busy_q, busy_d;

  always_comb begin
    tick     = (presc_q == PW'(DEBOUNCE - 1));
    presc_d  = tick ? '0 : presc_q + 1'b1;
    hist1_d  = tick ? hist0_q : hist1_q;
    hist0_d  = tick ? sync2_q : hist0_q;
    // 11 forces high, 00 forces low, mixed history keeps the previous level
    deb_d    = (deb_q | (hist1_d & hist0_d)) & (hist1_d | hist0_d);
    press    = deb_d & ~deb_q;
    clr_mask = (door == 2'd1) ? (FLOORS'(1) << current_floor) : '0;
  end

  // Round-robin search; the floor already on req_floor is only taken when it is
  // the sole candidate, and is then preceded by a one-cycle different value.
  always_comb begin
    avail = lamps_q & ~sent_q;
    others = avail & ~(FLOORS'(1) << req_floor_q);
    fresh = ~|others;
    pool = fresh ? avail : others;
    cand = '0;
    idx = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= 8; k++) begin
      idx = 3'(last_q + 3'(k));
      if (!found && pool[idx]) begin
        cand  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    req_floor_d = req_floor_q;
    req_valid_d = req_valid_q;
    fresh_d     = fresh_q;
    last_d      = last_q;
    issue_mask  = '0;
    case (state_q)
      S_IDLE: begin
        req_valid_d = 1'b0;
        if (found && !emergency_stop) begin
          req_floor_d = fresh ? 3'(cand + 3'd1) : cand;
          req_valid_d = 1'b1;
          issue_mask  = FLOORS'(1) << cand;
          last_d      = cand;
          count_d     = CW'(HOLD - 1);
          fresh_d     = fresh;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (fresh_q) begin
          req_floor_d = last_q;
          fresh_d     = 1'b0;
        end else if (count_q == '0) begin
          req_valid_d = 1'b0;
          count_d     = CW'(GAP - 1);
          state_d     = S_GAP;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      S_GAP: begin
        if (count_q == '0) begin
          state_d = S_IDLE;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    sent_d  = (sent_q | issue_mask) & ~clr_mask;
    lamps_d = (lamps_q | press) & ~clr_mask;
    busy_d  = |lamps_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      presc_q     <= '0;
      hist0_q     <= '0;
      hist1_q     <= '0;
      deb_q       <= '0;
      lamps_q     <= '0;
      sent_q      <= '0;
      last_q      <= 3'd7;
      state_q     <= S_IDLE;
      count_q     <= '0;
      req_floor_q <= '0;
      req_valid_q <= 1'b0;
      fresh_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sync1_q     <= btn;
      sync2_q     <= sync1_q;
      presc_q     <= presc_d;
      hist0_q     <= hist0_d;
      hist1_q     <= hist1_d;
      deb_q       <= deb_d;
      lamps_q     <= lamps_d;
      sent_q      <= sent_d;
      last_q      <= last_d;
      state_q     <= state_d;
      count_q     <= count_d;
      req_floor_q <= req_floor_d;
      req_valid_q <= req_valid_d;
      fresh_q     <= fresh_d;
      busy_q      <= busy_d;
    end
  end

  assign req_floor = req_floor_q;
  assign req_valid = req_valid_q;
  assign lamps     = lamps_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_floor_call_panel.sv
// Scoreboard bench for floor_call_panel: expected issues are queued by the
// stimulus, a negedge monitor measures each req_valid window and compares.
module tb_floor_call_panel;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] btn = '0;
  logic [2:0] current_floor = '0;
  logic [1:0] door = '0;
  logic       emergency_stop = 1'b0;
  logic [2:0] req_floor;
  logic       req_valid;
  logic [7:0] lamps;
  logic       busy;

  always #5 clk = ~clk;

  floor_call_panel #(.FLOORS(8), .DEBOUNCE(4), .HOLD(3), .GAP(2)) dut (
    .clk(clk), .reset(reset), .btn(btn), .current_floor(current_floor),
    .door(door), .emergency_stop(emergency_stop), .req_floor(req_floor),
    .req_valid(req_valid), .lamps(lamps), .busy(busy)
  );

  typedef struct {
    logic [2:0]  first;
    logic [2:0]  floor;
    int unsigned len;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic expect_issue(input logic [2:0] first, input logic [2:0] floor, input int unsigned len);
    exp_t e;
    e.first = first;
    e.floor = floor;
    e.len   = len;
    exp_q.push_back(e);
  endtask

  // Monitor: one scoreboard pop per completed req_valid window
  logic        prev_v = 1'b0;
  logic        seen = 1'b0;
  int unsigned win_len = 0;
  int unsigned low_cnt = 0;
  logic [2:0]  first_f = '0;
  logic [2:0]  last_f = '0;

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      prev_v  = 1'b0;
      seen    = 1'b0;
      win_len = 0;
      low_cnt = 0;
    end else if (req_valid) begin
      if (!prev_v) begin
        if (seen) begin
          n_cmp++;
          if (low_cnt < 3) begin
            n_bad++;
            $display("FAIL gap_low_cycles: got %0d expected >= 3", low_cnt);
          end
        end
        first_f = req_floor;
        win_len = 0;
      end
      win_len++;
      last_f = req_floor;
      prev_v = 1'b1;
    end else begin
      if (prev_v) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_issue: got floor %0d len %0d expected none", last_f, win_len);
        end else begin
          e = exp_q.pop_front();
          check("issue_first_floor", 32'(first_f), 32'(e.first));
          check("issue_floor", 32'(last_f), 32'(e.floor));
          check("issue_valid_len", win_len, e.len);
        end
        seen    = 1'b1;
        low_cnt = 0;
      end
      low_cnt++;
      prev_v = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [7:0] m);
    btn = btn | m;
    tick(16);
    btn = btn & ~m;
    tick(12);
  endtask

  task automatic wait_idle(input string name);
    int unsigned k;
    k = 0;
    while ((exp_q.size() != 0 || req_valid) && k < 200) begin
      tick(1);
      k++;
    end
    if (k >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got %0d pending issues expected 0 within 200 cycles", name, exp_q.size());
    end
    tick(4);
  endtask

  task automatic wait_valid(input logic level, input string name);
    int unsigned k;
    k = 0;
    while (req_valid !== level && k < 50) begin
      tick(1);
      k++;
    end
    if (k >= 50) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got req_valid %0b expected %0b within 50 cycles", name, req_valid, level);
    end
  endtask

  task automatic serve(input logic [2:0] f);
    current_floor = f;
    door = 2'd1;
    tick(1);
    door = 2'd0;
    check("serve_lamp_clear", 32'(lamps[f]), 32'd0);
  endtask

  initial begin
    // Reset with all buttons pressed
    reset = 1'b0;
    btn = 8'hFF;
    tick(2);
    check("reset_req_floor", 32'(req_floor), 32'd0);
    check("reset_req_valid", 32'(req_valid), 32'd0);
    check("reset_lamps", 32'(lamps), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    btn = '0;
    reset = 1'b1;
    tick(3);
    check("post_reset_lamps", 32'(lamps), 32'd0);

    // 3-cycle glitch can be sampled at most once
    btn[2] = 1'b1;
    tick(3);
    btn[2] = 1'b0;
    tick(20);
    check("glitch_rejected", 32'(lamps), 32'd0);

    // Single press on floor 5
    expect_issue(3'd5, 3'd5, 3);
    press(8'h20);
    check("press5_lamps", 32'(lamps), 32'h20);
    check("press5_busy", 32'(busy), 32'd1);
    wait_idle("press5_issue");
    serve(3'd5);
    check("busy_lags_lamps", 32'(busy), 32'd1);
    tick(1);
    check("busy_drop", 32'(busy), 32'd0);

    // Press while the door is open at that floor: served immediately
    current_floor = 3'd3;
    door = 2'd1;
    btn[3] = 1'b1;
    tick(20);
    door = 2'd0;
    btn[3] = 1'b0;
    tick(12);
    check("clear_beats_press", 32'(lamps), 32'd0);

    // Round-robin from last_issued=4: 6 then 1, 4 stays sent
    expect_issue(3'd4, 3'd4, 3);
    press(8'h10);
    wait_idle("rr_issue4");
    expect_issue(3'd6, 3'd6, 3);
    expect_issue(3'd1, 3'd1, 3);
    press(8'h42);
    wait_idle("rr_issue61");
    tick(20);
    check("rr_lamps", 32'(lamps), 32'h52);
    serve(3'd4);
    serve(3'd6);
    serve(3'd1);
    tick(2);
    check("rr_cleared", 32'(lamps), 32'd0);

    // Set last_issued=7, then block issues with emergency_stop
    expect_issue(3'd7, 3'd7, 3);
    press(8'h80);
    wait_idle("estop_prep");
    serve(3'd7);
    emergency_stop = 1'b1;
    press(8'h81);
    tick(10);
    check("estop_no_issue", 32'(req_valid), 32'd0);
    check("estop_lamps", 32'(lamps), 32'h81);
    expect_issue(3'd0, 3'd0, 3);
    expect_issue(3'd7, 3'd7, 3);
    emergency_stop = 1'b0;
    wait_valid(1'b1, "estop_release_issue");
    emergency_stop = 1'b1;
    wait_valid(1'b0, "estop_issue_end");
    emergency_stop = 1'b0;
    wait_idle("estop_issues");
    serve(3'd0);
    serve(3'd7);

    // Freshness: only candidate equals req_floor=7, wraps to 0 first
    expect_issue(3'd0, 3'd7, 4);
    press(8'h80);
    wait_idle("fresh_issue");
    serve(3'd7);
    tick(2);
    check("final_lamps", 32'(lamps), 32'd0);
    check("final_busy", 32'(busy), 32'd0);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
